alu_result_uart_tx: RTL and testbench
=====================================

# alu_result_uart_tx

Serial reporter for the 8-bit ALU on the FPGA board. On a `start` pulse it captures the ALU result, the Zero and Cout flags, and the active operation select. It then transmits them to a host PC as two back-to-back UART 8N1 bytes. It sits between the ALU outputs and the board's UART TX pin, alongside the LED outputs.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range is 2 or more.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to send a report; sampled every cycle.
- `result`  in  8  ALU result (ALU_Out).
- `zero`  in  1  ALU Zero flag.
- `cout`  in  1  ALU carry-out flag.
- `alu_sel`  in  3  ALU operation select in effect.
- `tx`  out  1  UART serial line; idle-high.
- `busy`  out  1  high while a report is being transmitted.
- `done`  out  1  single-cycle pulse when a report finishes.

## Operation
- **Capture:** in IDLE, `start`=1 latches two bytes into internal registers:
  - byte0 = `result`
  - byte1 = {1'b0, `alu_sel`[2:0], 2'b00, `cout`, `zero`}
- After capture, input changes have no effect on the report in flight.
- **Ignored starts:** `start` while `busy`=1 is dropped. It is not queued.
- **Frame per byte:** 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- **Byte order:** byte0 is sent first. byte1's start bit follows byte0's stop bit immediately, with no idle gap.
- **State machine:**
  - IDLE → START on `start`
  - START → DATA after CLKS_PER_BIT cycles
  - DATA → STOP after 8 bits, using bit index 0..7
  - STOP → START if byte0 was just sent, otherwise → IDLE
- **Baud counter:** counts 0..CLKS_PER_BIT-1. It wraps to 0 on every bit boundary and is held at 0 in IDLE.
- **Byte select:** a 1-bit byte select chooses between byte0 and byte1. It is cleared on capture.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `done`=0, state=IDLE, counters=0.
- **Start of report:** `start` high at edge N gives `busy`=1 and `tx`=0 from edge N, i.e. visible in cycle N+1.
- **Bit length:** every bit is exactly CLKS_PER_BIT cycles.
- **Report length:** a full report is 20·CLKS_PER_BIT cycles of `busy`=1.
- **End of report:** at the edge ending byte1's stop bit:
  - state returns to IDLE
  - `busy`=0
  - `done`=1 for exactly that one cycle
  - `tx` stays 1
- **Back-to-back:** `start` asserted during the `done` cycle is accepted. The next start bit begins on the following edge.
- **Reset mid-report:** `tx` is 1 from the next edge. The report is abandoned, no `done` is produced, and `busy`=0.
- **`tx` is registered:** it comes straight from a flop with no combinational path from inputs.

## Structure
- **Package `alu_uart_pkg`:**
  - state enum {IDLE, START, DATA, STOP}
  - `UART_IDLE_LVL`=1'b1
  - `BYTES_PER_REPORT`=2
  - function packing byte1 from sel/cout/zero
- **Sub-module `baud_tick_gen`:**
  - parameter CLKS_PER_BIT
  - inputs `clk`, `rst`, `en`
  - output `tick`, high on the last cycle of each bit
  - the FSM advances only on `tick`

## Test plan
Run all scenarios with CLKS_PER_BIT=4.
1. **Basic report:**
   - Stimulus: reset, then `start` pulse with result=0xA5, zero=0, cout=1, alu_sel=3'b010.
   - Required response:
     - `tx` decodes to 0xA5 then 0x22
     - each bit is 4 cycles wide
     - `busy` is high for 80 cycles
     - one `done` pulse appears
2. **Zero flag, capture hold:**
   - Stimulus: result=0x00, zero=1, cout=0, alu_sel=3'b111; change all inputs on the cycle after `start`.
   - Required response: bytes 0x00, 0x71; later input changes do not appear.
3. **Start while busy:**
   - Stimulus: pulse `start` at cycles 10 and 40 of a report.
   - Required response: exactly one report of 80 cycles and one `done`.
4. **Back-to-back:**
   - Stimulus: hold `start`=1 continuously.
   - Required response:
     - reports repeat with `busy` low for only the `done` cycle
     - the second report's start bit begins immediately after
5. **Reset mid-frame:**
   - Stimulus: assert `rst` during byte0 data bit 3.
   - Required response:
     - next cycle `tx`=1, `busy`=0
     - no `done`
     - a new `start` afterwards produces a clean full report
6. **Reset values:**
   - Stimulus: assert `rst` with `start`=1.
   - Required response: `tx`=1, `busy`=0, `done`=0 throughout.

Source files
------------

// File: rtl/alu_uart_pkg.sv
// rtl/alu_uart_pkg.sv - shared types and helpers for the ALU result UART reporter
package alu_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic UART_IDLE_LVL    = 1'b1;
    localparam int   BYTES_PER_REPORT = 2;

    // Second report byte: {0, sel[2:0], 00, cout, zero}
    function automatic logic [7:0] pack_byte1(input logic [2:0] sel,
                                              input logic cout,
                                              input logic zero);
        return {1'b0, sel, 2'b00, cout, zero};
    endfunction

endpackage

// File: rtl/alu_result_uart_tx_baud_tick_gen.sv
// rtl/alu_result_uart_tx_baud_tick_gen.sv - bit-period counter with end-of-bit tick
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Held at zero while disabled so the first bit after enable is full length
    always_ff @(posedge clk) begin
        if (rst || !en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_result_uart_tx.sv
// rtl/alu_result_uart_tx.sv - captures ALU result/flags and sends them as two UART 8N1 bytes
module alu_result_uart_tx
    import alu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] result,
    input  logic       zero,
    input  logic       cout,
    input  logic [2:0] alu_sel,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic LAST_BYTE = 1'(BYTES_PER_REPORT - 1);

    state_t     state;
    logic [7:0] byte0;
    logic [7:0] byte1;
    logic       byte_sel;
    logic [2:0] bit_idx;
    logic [7:0] cur_byte;
    logic       tick;

    assign cur_byte = byte_sel ? byte1 : byte0;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (state != IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= UART_IDLE_LVL;
            busy     <= 1'b0;
            done     <= 1'b0;
            byte0    <= '0;
            byte1    <= '0;
            byte_sel <= 1'b0;
            bit_idx  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        byte0    <= result;
                        byte1    <= pack_byte1(alu_sel, cout, zero);
                        byte_sel <= 1'b0;
                        bit_idx  <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx      <= cur_byte[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            tx    <= UART_IDLE_LVL;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end
                end
                STOP: begin
                    // Next byte's start bit follows the stop bit with no idle gap
                    if (tick) begin
                        if (byte_sel != LAST_BYTE) begin
                            byte_sel <= ~byte_sel;
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// tb/tb_alu_result_uart_tx.sv - randomized directed bench for alu_result_uart_tx
module tb_alu_result_uart_tx;

    localparam int CPB = 4;
    localparam int REPORT_CYCLES = 20 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] result;
    logic       zero;
    logic       cout;
    logic [2:0] alu_sel;
    logic       tx;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    alu_result_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .result  (result),
        .zero    (zero),
        .cout    (cout),
        .alu_sel (alu_sel),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_inputs();
        result  = 8'($urandom);
        zero    = 1'($urandom);
        cout    = 1'($urandom);
        alu_sel = 3'($urandom);
    endtask

    // Caller has driven start=1 and the inputs at a negedge; the next posedge captures.
    task automatic do_report(input bit poke, input bit hold);
        logic [7:0] exp_b0;
        logic [7:0] exp_b1;
        logic       line [20];
        logic       rx   [20];
        logic [7:0] got_b0;
        logic [7:0] got_b1;
        exp_b0 = result;
        exp_b1 = 8'(alu_sel * 16 + cout * 2 + zero);
        for (int b = 0; b < 2; b++) begin
            line[b*10] = 1'b0;
            for (int k = 0; k < 8; k++)
                line[b*10 + 1 + k] = (b == 0) ? exp_b0[k] : exp_b1[k];
            line[b*10 + 9] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        randomize_inputs();
        for (int i = 0; i < REPORT_CYCLES; i++) begin
            check($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
            check($sformatf("tx[%0d]", i), 32'(tx), 32'(line[i / CPB]));
            check($sformatf("done[%0d]", i), 32'(done), 32'd0);
            if (i % CPB == CPB / 2) rx[i / CPB] = tx;
            if (poke) start = (i == 10 || i == 40);
            @(negedge clk);
        end
        check("end_busy", 32'(busy), 32'd0);
        check("end_done", 32'(done), 32'd1);
        check("end_tx", 32'(tx), 32'd1);
        for (int k = 0; k < 8; k++) begin
            got_b0[k] = rx[1 + k];
            got_b1[k] = rx[11 + k];
        end
        check("rx_byte0", 32'(got_b0), 32'(exp_b0));
        check("rx_byte1", 32'(got_b1), 32'(exp_b1));
        if (!hold) begin
            start = 1'b0;
            @(negedge clk);
            check("post_busy", 32'(busy), 32'd0);
            check("post_done", 32'(done), 32'd0);
            check("post_tx", 32'(tx), 32'd1);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b1;
        result  = 8'h00;
        zero    = 1'b0;
        cout    = 1'b0;
        alu_sel = 3'b000;

        // Reset held with start asserted
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_tx", 32'(tx), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle_tx", 32'(tx), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // Basic report 0xA5 / 0x22
        result = 8'hA5; zero = 1'b0; cout = 1'b1; alu_sel = 3'b010; start = 1'b1;
        do_report(1'b0, 1'b0);

        // Zero flag; inputs change right after capture
        result = 8'h00; zero = 1'b1; cout = 1'b0; alu_sel = 3'b111; start = 1'b1;
        do_report(1'b0, 1'b0);

        // Starts during a report are dropped
        randomize_inputs(); start = 1'b1;
        do_report(1'b1, 1'b0);

        // Back-to-back with start held high
        randomize_inputs(); start = 1'b1;
        do_report(1'b0, 1'b1);
        do_report(1'b0, 1'b1);
        do_report(1'b0, 1'b0);

        // Reset during byte0 data bit 3
        randomize_inputs(); start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4 * CPB + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < REPORT_CYCLES; i++) begin
            @(negedge clk);
            check("midrst_nodone", 32'(done), 32'd0);
            check("midrst_idle", 32'(busy), 32'd0);
        end
        randomize_inputs(); start = 1'b1;
        do_report(1'b0, 1'b0);

        // Random reports
        for (int r = 0; r < 4; r++) begin
            randomize_inputs(); start = 1'b1;
            do_report(1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
